// File: rtl/edge_pixel_reader.sv
// Read side of the edge-detect pixel FIFO: frame-aligned popping with prefill and underrun
// recovery, feeding a fixed 2-stage pixel pipeline (edge grey or RGB pass-through) to the VGA side.
//
// state     | meaning
// IDLE      | frame complete or after reset; waiting for a frame pulse
// PREFILL   | waiting for the FIFO to reach PREFILL_LEVEL words, no pops
// STREAM    | one pop per VGA request, raster counters advancing
// UNDERRUN  | FIFO ran dry mid-frame; black until the next frame pulse
module edge_pixel_reader #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int PREFILL_LEVEL = 16,
    parameter int USEDW_W       = 10
) (
    input  logic               CCD_FIFO_RDCLK,
    input  logic               iRST,
    input  logic [29:0]        iFIFO_DATA,
    input  logic               iFIFO_EMPTY,
    input  logic [USEDW_W-1:0] iFIFO_USEDW,
    output logic               oFIFO_RDREQ,
    input  logic               iVGA_FRAME,
    input  logic               iVGA_REQ,
    input  logic               iEDGE_MODE,
    input  logic               iTHRESH_EN,
    input  logic [9:0]         iTHRESH,
    output logic [9:0]         oRed,
    output logic [9:0]         oGreen,
    output logic [9:0]         oBlue,
    output logic               oUNDERRUN,
    output logic [15:0]        oUNDER_CNT
);

    localparam int HCNT_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int VCNT_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [HCNT_W-1:0]  H_LAST    = HCNT_W'(H_ACTIVE - 1);
    localparam logic [VCNT_W-1:0]  V_LAST    = VCNT_W'(V_ACTIVE - 1);
    localparam logic [USEDW_W-1:0] PREFILL_W = USEDW_W'(PREFILL_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFILL  = 2'd1,
        S_STREAM   = 2'd2,
        S_UNDERRUN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              edge_mode_q, edge_mode_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       under_cnt_q, under_cnt_d;
    logic              rdreq;

    logic              vld_s1_q, vld_s1_d;
    logic              mode_s1_q, mode_s1_d;
    logic [29:0]       rgb_q, rgb_d;
    logic [9:0]        mag_sat;
    logic              mag_hit;
    logic [9:0]        grey;

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        edge_mode_d = edge_mode_q;
        underrun_d  = underrun_q;
        under_cnt_d = under_cnt_q;
        rdreq       = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_PREFILL: begin
                if (iFIFO_USEDW >= PREFILL_W) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                rdreq = iVGA_REQ & ~iFIFO_EMPTY;
                if (rdreq) begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_d = '0;
                        if (vcnt_q == V_LAST) begin
                            vcnt_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            vcnt_d = vcnt_q + VCNT_W'(1);
                        end
                    end else begin
                        hcnt_d = hcnt_q + HCNT_W'(1);
                    end
                end else if (iVGA_REQ) begin
                    state_d     = S_UNDERRUN;
                    underrun_d  = 1'b1;
                    under_cnt_d = (under_cnt_q == 16'hFFFF) ? under_cnt_q : under_cnt_q + 16'd1;
                end
            end
            S_UNDERRUN: ;
            default: state_d = S_IDLE;
        endcase

        // A frame pulse always realigns; only a normal frame start clears the sticky flag.
        if (iVGA_FRAME) begin
            state_d     = S_PREFILL;
            hcnt_d      = '0;
            vcnt_d      = '0;
            edge_mode_d = iEDGE_MODE;
            if (state_q == S_IDLE || state_q == S_UNDERRUN) begin
                underrun_d = 1'b0;
            end
        end

        // No pop during a reset cycle: the word would be lost when the pipeline is flushed.
        if (iRST) begin
            rdreq = 1'b0;
        end
    end

    always_ff @(posedge CCD_FIFO_RDCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            edge_mode_q <= 1'b0;
            underrun_q  <= 1'b0;
            under_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            edge_mode_q <= edge_mode_d;
            underrun_q  <= underrun_d;
            under_cnt_q <= under_cnt_d;
        end
    end

    // The mode travels with each pixel so a realigning frame pulse cannot recolour words in flight.
    always_comb begin
        vld_s1_d  = rdreq;
        mode_s1_d = edge_mode_q;
        mag_sat   = (iFIFO_DATA > 30'd1023) ? 10'h3FF : iFIFO_DATA[9:0];
        mag_hit   = (iFIFO_DATA >= {20'd0, iTHRESH});
        grey      = iTHRESH_EN ? {10{mag_hit}} : mag_sat;
        rgb_d     = '0;
        if (vld_s1_q) begin
            rgb_d = mode_s1_q ? {grey, grey, grey} : iFIFO_DATA;
        end
    end

    always_ff @(posedge CCD_FIFO_RDCLK) begin
        if (iRST) begin
            vld_s1_q  <= 1'b0;
            mode_s1_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            vld_s1_q  <= vld_s1_d;
            mode_s1_q <= mode_s1_d;
            rgb_q     <= rgb_d;
        end
    end

    assign oFIFO_RDREQ = rdreq;
    assign oRed        = rgb_q[29:20];
    assign oGreen      = rgb_q[19:10];
    assign oBlue       = rgb_q[9:0];
    assign oUNDERRUN   = underrun_q;
    assign oUNDER_CNT  = under_cnt_q;

endmodule
